pos_to_word: RTL
================

Name: pos_to_word

Overview:
- Inverse of the single-bit position detector: rebuilds a 32-bit data word from a stream of bit positions, one position per beat.
- Positions arrive on a valid/ready input channel. Each accepted position sets its bit in an accumulator.
- On the closing beat, the assembled word is presented on a valid/ready output channel together with a set-bit count and error flags.
- Sits downstream of the detector in the encode/decode round-trip path and in compression-style bit-list links.

Parameters:
- DATA_W, 32, output word width; must be 32 for this revision.
- POS_W, 6, position width; value 32 is the "no bit" code.
- MAX_BEATS, 32, beat limit per word; when reached, the word is force-closed.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  position beat valid
- in_ready  out  1  block can accept a beat
- in_pos  in  6  bit index 0..31; 32 = no bit set; 33..63 invalid
- in_last  in  1  beat closes the current word
- out_valid  out  1  assembled word available
- out_ready  in  1  consumer accepts word
- out_data  out  32  assembled word
- out_count  out  6  number of distinct bits set in out_data (0..32)
- out_err  out  2  [0] invalid position seen, [1] duplicate position seen

Behaviour:
- Reset (rst_n low, asynchronous): state=ACCUM, accumulator=0, beat counter=0, count=0, error flags=0.
  - Output reset values: in_ready=0, out_valid=0, out_data=0, out_count=0, out_err=0.
  - in_ready rises on the first clk edge after rst_n deasserts.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Beat accept = in_valid & in_ready. Per accepted beat:
  - pos 0..31, bit clear: set bit, count+1.
  - pos 0..31, bit already set: accumulator unchanged, err[1] set (sticky for this word).
  - pos 32: no change, legal. A word of only pos 32 yields data 0, count 0, no error.
  - pos 33..63: no change, err[0] set (sticky for this word).
  - Beat counter increments on every accepted beat.
- Close condition: accepted beat with in_last=1, or the beat counter reaching MAX_BEATS on this beat.
  - On the close edge: out_data, out_count and out_err are registered including the closing beat's effect; state goes to HOLD.
  - Latency: out_valid is high the cycle after the closing beat is accepted.
- HOLD:
  - out_data, out_count and out_err stay stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: state goes to ACCUM; accumulator, counters and flags clear.
  - in_ready=1 the next cycle, so there is one bubble cycle between words.
- Zero-beat words are impossible; a word always contains at least one beat.
- Reset mid-word or in HOLD: the partial or held word is discarded; no output is produced.
- in_valid with in_ready=0 has no effect. The source must hold in_pos and in_last stable until accepted.

Optional Feature:
- Macro: POS_ORDER_CHECK_EN.
- When defined: out_err widens to 3 bits.
  - err[2] is set if any accepted pos in 0..31 is not strictly lower than the previous pos 0..31 of the same word. This is the descending order in which the detector emits leading ones.
  - pos 32 and invalid positions are ignored for ordering.
- When undefined: out_err is 2 bits, there is no ordering logic, and position order is irrelevant.

Test Plan:
- Reset then single beat pos=5, last=1 -> one cycle later out_valid=1, out_data=0x00000020, out_count=1, out_err=0; hold out_ready=0 for 3 cycles and the outputs stay stable.
- Beats 31,16,0 (last on 0) -> out_data=0x80010001, count=3, err=0; with POS_ORDER_CHECK_EN, err[2]=0.
- Beats 3,3,7 (last) -> out_data=0x00000088, count=2, err=2'b10; with the macro, err[2]=1.
- Beats 40 then 32 (last) -> out_data=0, count=0, err=2'b01.
- 32 beats of pos 0..31 ascending with no last -> force-close after the 32nd beat, out_data=0xFFFFFFFF, count=32; in_ready low in HOLD, high one cycle after the out handshake.
- Assert rst_n low mid-word after beats 1,2 -> all outputs at reset values immediately; new word pos=4 (last) -> out_data=0x00000010, count=1.

Source files
------------

// File: rtl/pos_to_word.sv
// pos_to_word: rebuilds a DATA_W-bit word from a stream of single-bit positions.
//
// Each accepted position beat sets its bit in an accumulator. A beat with
// in_last, or the MAX_BEATS-th beat of a word, closes the word. The word,
// its set-bit count and error flags are then offered on the output channel.
//
// Optional feature (macro POS_ORDER_CHECK_EN): out_err gains bit [2], which
// flags any in-range position that is not strictly below the previous
// in-range position of the same word.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   position beat handshake
//   in_pos              bit index 0..31, 32 = no bit, 33..63 invalid
//   in_last             beat closes the current word
//   out_valid/out_ready assembled word handshake
//   out_data            assembled word
//   out_count           number of distinct bits set in out_data
//   out_err             [0] invalid position, [1] duplicate, [2] order (optional)
module pos_to_word #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned POS_W     = 6,
    parameter int unsigned MAX_BEATS = 32
`ifdef POS_ORDER_CHECK_EN
    , localparam int unsigned ERR_W  = 3
`else
    , localparam int unsigned ERR_W  = 2
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [POS_W-1:0]              in_pos,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(DATA_W+1)-1:0]   out_count,
    output logic [ERR_W-1:0]              out_err
);

    localparam int unsigned IDX_W  = $clog2(DATA_W);
    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
    localparam int unsigned BCNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [POS_W-1:0]  NONE_POS  = POS_W'(DATA_W);
    localparam logic [BCNT_W-1:0] BEAT_LIM  = BCNT_W'(MAX_BEATS);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [BCNT_W-1:0]   beats_q, beats_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                in_ready_d, out_valid_d;
    logic [DATA_W-1:0]   out_data_d;
    logic [CNT_W-1:0]    out_count_d;
    logic [ERR_W-1:0]    out_err_d;
`ifdef POS_ORDER_CHECK_EN
    logic [IDX_W-1:0]    prev_q, prev_d;
    logic                prev_vld_q, prev_vld_d;
`endif

    logic                accept;
    logic                pos_in_range;
    logic                pos_invalid;
    logic [IDX_W-1:0]    idx;

    assign accept       = in_valid & in_ready;
    assign pos_in_range = (in_pos < NONE_POS);
    assign pos_invalid  = (in_pos > NONE_POS);
    assign idx          = in_pos[IDX_W-1:0];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            beats_q    <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_count  <= '0;
            out_err    <= '0;
`ifdef POS_ORDER_CHECK_EN
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            beats_q    <= beats_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            in_ready   <= in_ready_d;
            out_valid  <= out_valid_d;
            out_data   <= out_data_d;
            out_count  <= out_count_d;
            out_err    <= out_err_d;
`ifdef POS_ORDER_CHECK_EN
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
`endif
        end
    end

    // Next-state, accumulation and output staging
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_data_d  = out_data;
        out_count_d = out_count;
        out_err_d   = out_err;
`ifdef POS_ORDER_CHECK_EN
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
`endif

        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    beats_d = BCNT_W'(beats_q + 1'b1);
                    if (pos_in_range) begin
                        if (acc_q[idx]) begin
                            err_d[1] = 1'b1;
                        end else begin
                            acc_d[idx] = 1'b1;
                            cnt_d      = CNT_W'(cnt_q + 1'b1);
                        end
`ifdef POS_ORDER_CHECK_EN
                        // Detector emits leading ones high to low; anything else is out of order
                        if (prev_vld_q && (idx >= prev_q)) begin
                            err_d[2] = 1'b1;
                        end
                        prev_d     = idx;
                        prev_vld_d = 1'b1;
`endif
                    end else if (pos_invalid) begin
                        err_d[0] = 1'b1;
                    end

                    // Close captures the closing beat's own effect
                    if (in_last || (beats_d == BEAT_LIM)) begin
                        out_data_d  = acc_d;
                        out_count_d = cnt_d;
                        out_err_d   = err_d;
                        state_d     = HOLD;
                    end
                end
            end

            HOLD: begin
                if (out_valid && out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    beats_d = '0;
                    cnt_d   = '0;
                    err_d   = '0;
`ifdef POS_ORDER_CHECK_EN
                    prev_d     = '0;
                    prev_vld_d = 1'b0;
`endif
                end
            end

            default: state_d = ACCUM;
        endcase

        // Handshake flags follow the state being entered
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == HOLD);
    end

endmodule
